// File: rtl/csr_axil_arbiter.sv
// csr_axil_arbiter: shares one AXI-Lite CSR slave between two req/ack
// clients. Round-robin grant on ties, one transaction in flight at a time,
// every AXI output driven straight from a register.
module csr_axil_arbiter #(
  parameter int DATA_W = 32,
  parameter int STRB_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  // requester 0
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [STRB_W-1:0] r0_wstrb,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  // requester 1
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [STRB_W-1:0] r1_wstrb,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              busy,
  // AXI-Lite master
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_DATA = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t              state_q;
  logic                last_grant_q;
  logic                grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                aw_ok_q;
  logic                w_ok_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic                arvalid_q;
  logic                rready_q;
  logic [1:0]          ack_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic                req_any_d;
  logic                grant_d;
  logic                sel_we_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  logic [STRB_W-1:0]   sel_wstrb_d;
  logic                aw_done_d;
  logic                w_done_d;

  // Arbitration: a lone request wins outright, a tie goes to whoever did not win last.
  always_comb begin
    req_any_d = r0_req | r1_req;
    if (r0_req && r1_req) begin
      grant_d = ~last_grant_q;
    end else begin
      grant_d = r1_req;
    end
    sel_we_d    = grant_d ? r1_we    : r0_we;
    sel_addr_d  = grant_d ? r1_addr  : r0_addr;
    sel_wdata_d = grant_d ? r1_wdata : r0_wdata;
    sel_wstrb_d = grant_d ? r1_wstrb : r0_wstrb;
    // A channel counts as done if it finished earlier or handshakes this cycle.
    aw_done_d   = aw_ok_q | (awvalid_q & awready);
    w_done_d    = w_ok_q  | (wvalid_q  & wready);
  end

  // Transaction sequencer; all AXI and client outputs are registered here.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      ack_q        <= 2'b00;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_any_d) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            addr_q       <= sel_addr_d;
            wdata_q      <= sel_wdata_d;
            wstrb_q      <= sel_wstrb_d;
            aw_ok_q      <= 1'b0;
            w_ok_q       <= 1'b0;
            awvalid_q    <= sel_we_d;
            wvalid_q     <= sel_we_d;
            arvalid_q    <= ~sel_we_d;
            state_q      <= sel_we_d ? S_WR : S_RD_ADDR;
          end
        end
        S_WR: begin
          // AW and W retire independently; each valid drops after its own handshake.
          if (awvalid_q && awready) begin
            awvalid_q <= 1'b0;
            aw_ok_q   <= 1'b1;
          end
          if (wvalid_q && wready) begin
            wvalid_q <= 1'b0;
            w_ok_q   <= 1'b1;
          end
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
            state_q  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            err_q    <= (bresp != 2'b00);
            rdata_q  <= '0;
            ack_q    <= grant_q ? 2'b10 : 2'b01;
            state_q  <= S_DONE;
          end
        end
        S_RD_ADDR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            rdata_q  <= rdata;
            err_q    <= (rresp != 2'b00);
            ack_q    <= grant_q ? 2'b10 : 2'b01;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          ack_q   <= 2'b00;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign awaddr   = addr_q;
  assign araddr   = addr_q;
  assign wdata    = wdata_q;
  assign wstrb    = wstrb_q;
  assign awvalid  = awvalid_q;
  assign wvalid   = wvalid_q;
  assign bready   = bready_q;
  assign arvalid  = arvalid_q;
  assign rready   = rready_q;
  assign r0_ack   = ack_q[0];
  assign r1_ack   = ack_q[1];
  assign r0_rdata = rdata_q;
  assign r1_rdata = rdata_q;
  assign r0_err   = err_q;
  assign r1_err   = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule
